// File: rtl/rtm_sequencer.sv
// Micro-op sequencer for the 4x4-bit register-transfer datapath: accepts one
// instruction per handshake and drives timed selects, write strobes and clear.
module rtm_sequencer #(
    parameter int DW     = 4,
    parameter int NREG   = 4,
    parameter int SETTLE = 2
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [1:0]      instr_op,
    input  logic [1:0]      instr_rd,
    input  logic [1:0]      instr_ra,
    input  logic [1:0]      instr_rb,
    input  logic [DW-1:0]   instr_imm,
    input  logic            carry_out,
    output logic [DW-1:0]   indata,
    output logic            ctl_add,
    output logic [1:0]      ctl_sa,
    output logic [1:0]      ctl_sb,
    output logic            carry_in,
    output logic [NREG-1:0] wr_en,
    output logic            rf_clear,
    output logic            flag_c,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WRITE, S_DONE} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_ADC, OP_CLRALL} op_t;

    localparam logic [3:0] CNT_INIT = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t     state;
    op_t        op_q;
    logic [1:0] rd_q;
    logic [3:0] cnt;

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= S_IDLE;
            op_q        <= OP_LOAD;
            rd_q        <= '0;
            cnt         <= '0;
            instr_ready <= 1'b0;
            indata      <= '0;
            ctl_add     <= 1'b0;
            ctl_sa      <= '0;
            ctl_sb      <= '0;
            carry_in    <= 1'b0;
            wr_en       <= '0;
            rf_clear    <= 1'b0;
            flag_c      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            wr_en    <= '0;
            rf_clear <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    instr_ready <= 1'b1;
                    if (instr_valid && instr_ready) begin
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        op_q        <= op_t'(instr_op);
                        rd_q        <= instr_rd;
                        case (op_t'(instr_op))
                            OP_LOAD: begin
                                ctl_add  <= 1'b0;
                                indata   <= instr_imm;
                                carry_in <= 1'b0;
                            end
                            OP_ADD: begin
                                ctl_add  <= 1'b1;
                                ctl_sa   <= instr_ra;
                                ctl_sb   <= instr_rb;
                                carry_in <= 1'b0;
                            end
                            OP_ADC: begin
                                ctl_add  <= 1'b1;
                                ctl_sa   <= instr_ra;
                                ctl_sb   <= instr_rb;
                                carry_in <= flag_c;
                            end
                            default: ;
                        endcase
                        // With no settle time the strobe must be issued straight from accept.
                        if (SETTLE == 0) begin
                            state <= S_WRITE;
                            if (op_t'(instr_op) == OP_CLRALL) rf_clear <= 1'b1;
                            else                             wr_en    <= NREG'(1) << instr_rd;
                        end else begin
                            state <= S_SETTLE;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt == 4'd0) begin
                        state <= S_WRITE;
                        if (op_q == OP_CLRALL) rf_clear <= 1'b1;
                        else                   wr_en    <= NREG'(1) << rd_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_WRITE: begin
                    case (op_q)
                        OP_ADD, OP_ADC: flag_c <= carry_out;
                        OP_CLRALL:      flag_c <= 1'b0;
                        default:        ;
                    endcase
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    instr_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtm_sequencer.sv
// Scoreboard bench for rtm_sequencer: a driver pushes expected per-instruction
// behaviour, a negedge monitor checks every output every cycle.
module tb_rtm_sequencer;

    localparam int unsigned ST = 2;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [1:0] instr_op = '0, instr_rd = '0, instr_ra = '0, instr_rb = '0;
    logic [3:0] instr_imm = '0;
    logic       carry_out = 1'b0;
    logic [3:0] indata;
    logic       ctl_add;
    logic [1:0] ctl_sa, ctl_sb;
    logic       carry_in;
    logic [3:0] wr_en;
    logic       rf_clear, flag_c, busy, done;

    rtm_sequencer #(.DW(4), .NREG(4), .SETTLE(ST)) dut (
        .clock(clock), .clear(clear), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
        .instr_imm(instr_imm), .carry_out(carry_out), .indata(indata), .ctl_add(ctl_add),
        .ctl_sa(ctl_sa), .ctl_sb(ctl_sb), .carry_in(carry_in), .wr_en(wr_en),
        .rf_clear(rf_clear), .flag_c(flag_c), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned start;
        logic [3:0]  wr;
        logic        clr;
        logic        add;
        logic [3:0]  ind;
        logic [1:0]  sa, sb;
        logic        cin;
        logic        c_before, c_after;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    logic        clr_q;
    int          vectors = 0;
    int          miscompares = 0;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        clr_q <= clear;
    end

    // Driver-side reference state, straight from the per-op control rules
    logic       m_c = 1'b0, m_add = 1'b0, m_cin = 1'b0;
    logic [3:0] m_ind = '0;
    logic [1:0] m_sa = '0, m_sb = '0;

    task automatic chk(input string name, input logic [18:0] act, input logic [18:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    // Monitor
    exp_t        cur;
    bit          inf = 1'b0;
    int unsigned idx;
    logic [18:0] a, e;
    logic        i_c = 1'b0, i_add = 1'b0, i_cin = 1'b0;
    logic [3:0]  i_ind = '0;
    logic [1:0]  i_sa = '0, i_sb = '0;

    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            a = {instr_ready, busy, done, wr_en, rf_clear, flag_c, ctl_add, indata, ctl_sa, ctl_sb, carry_in};
            if (clr_q) begin
                chk("reset_outputs", a, 19'h0);
                q.delete();
                inf = 1'b0;
                {i_c, i_add, i_cin, i_ind, i_sa, i_sb} = '0;
            end else begin
                if (!inf && q.size() > 0 && q[0].start <= cyc) begin
                    cur = q.pop_front();
                    inf = 1'b1;
                    idx = 0;
                end
                if (inf) begin
                    e = {1'b0, 1'b1, 1'(idx == ST + 1), (idx == ST) ? cur.wr : 4'b0,
                         1'((idx == ST) && cur.clr), (idx == ST + 1) ? cur.c_after : cur.c_before,
                         cur.add, cur.ind, cur.sa, cur.sb, cur.cin};
                    chk((idx == ST) ? "write_cycle" : (idx == ST + 1) ? "done_cycle" : "settle_cycle", a, e);
                    if (idx == ST + 1) begin
                        inf   = 1'b0;
                        i_c   = cur.c_after;
                        i_add = cur.add;
                        i_ind = cur.ind;
                        i_sa  = cur.sa;
                        i_sb  = cur.sb;
                        i_cin = cur.cin;
                    end
                    idx++;
                end else begin
                    e = {1'b1, 1'b0, 1'b0, 4'b0, 1'b0, i_c, i_add, i_ind, i_sa, i_sb, i_cin};
                    chk("idle_hold", a, e);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [3:0] imm, input logic cout, input bit keep);
        exp_t        x;
        int unsigned n = 0;
        while (instr_ready !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (instr_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout cyc=%0d got=%b want=1", cyc, instr_ready);
            instr_valid = 1'b0;
            return;
        end
        instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = imm;
        carry_out = cout;
        instr_valid = 1'b1;
        x.start    = cyc + 1;
        x.c_before = m_c;
        case (op)
            2'd0: begin m_add = 1'b0; m_ind = imm; m_cin = 1'b0; end
            2'd1: begin m_add = 1'b1; m_sa = ra; m_sb = rb; m_cin = 1'b0; end
            2'd2: begin m_add = 1'b1; m_sa = ra; m_sb = rb; m_cin = m_c; end
            default: ;
        endcase
        x.clr = (op == 2'd3);
        x.wr  = (op == 2'd3) ? 4'b0000 : 4'b0001 << rd;
        if (op == 2'd1 || op == 2'd2) m_c = cout;
        else if (op == 2'd3)          m_c = 1'b0;
        x.c_after = m_c;
        x.add = m_add; x.ind = m_ind; x.sa = m_sa; x.sb = m_sb; x.cin = m_cin;
        q.push_back(x);
        @(negedge clock);
        // Fields scrambled while busy must have no effect
        if (keep) begin
            instr_op = 2'($urandom); instr_rd = 2'($urandom); instr_ra = 2'($urandom);
            instr_rb = 2'($urandom); instr_imm = 4'($urandom);
        end else begin
            instr_valid = 1'b0;
        end
    endtask

    task automatic do_clear(input int unsigned cycles);
        clear = 1'b1;
        instr_valid = 1'b0;
        {m_c, m_add, m_cin, m_ind, m_sa, m_sb} = '0;
        repeat (cycles) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int unsigned n;
        repeat (2) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);

        issue(2'd0, 2'd2, 2'd0, 2'd0, 4'hA, 1'b0, 1'b0);   // LOAD r2 <- A
        issue(2'd1, 2'd3, 2'd0, 2'd1, 4'h0, 1'b1, 1'b0);   // ADD r3 = r0 + r1, carry 1
        issue(2'd2, 2'd0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0);   // ADC r0 with flag 1, carry 0
        issue(2'd3, 2'd0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0);   // CLRALL
        issue(2'd1, 2'd1, 2'd2, 2'd3, 4'h0, 1'b1, 1'b0);
        do_clear(2);                                        // abort during SETTLE
        for (int i = 0; i < 4; i++)
            issue(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 1'b1);

        for (int i = 0; i < 60; i++) begin
            bit keep = 1'($urandom);
            if (!keep) begin
                instr_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clock);
            end
            issue(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), keep);
            if ($urandom_range(0, 14) == 0) do_clear($urandom_range(1, 3));
        end
        instr_valid = 1'b0;

        n = 0;
        while ((q.size() > 0 || inf) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (q.size() > 0 || inf) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout pending=%0d want=0", q.size());
        end
        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
